// File: rtl/interval_timer_ctrl.sv
// Interval-timer controller: sequences a counter from a start bound to an end bound, in one-shot or periodic mode.
// Define INTERVAL_TIMER_PAUSE_EN to add the pause port and the PAUSED state.
module interval_timer_ctrl #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_from,
    input  logic [COUNT_WIDTH-1:0] cfg_to,
    input  logic                   cfg_periodic,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   tick,
`ifdef INTERVAL_TIMER_PAUSE_EN
    input  logic                   pause,
`endif
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
`ifdef INTERVAL_TIMER_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] from_q, from_d;
    logic [COUNT_WIDTH-1:0] to_q, to_d;
    logic                   periodic_q, periodic_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   cfg_ready_q, cfg_ready_d;

    logic                   cfg_xfer;
    logic [COUNT_WIDTH-1:0] eff_from, eff_to;

    // A configuration arriving in the same cycle as start takes effect immediately.
    assign cfg_xfer = cfg_valid & cfg_ready_q;
    assign eff_from = cfg_xfer ? cfg_from : from_q;
    assign eff_to   = cfg_xfer ? cfg_to   : to_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        from_d     = from_q;
        to_d       = to_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (cfg_xfer) begin
            from_d     = cfg_from;
            to_d       = cfg_to;
            periodic_d = cfg_periodic;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    if (eff_from > eff_to) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        count_d = eff_from;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
`ifdef INTERVAL_TIMER_PAUSE_EN
                end else if (pause) begin
                    state_d = S_PAUSED;
`endif
                end else if (tick) begin
                    // Terminal detection by compare so that to = all-ones never wraps.
                    if (count_q == to_q) begin
                        done_d = 1'b1;
                        if (periodic_q) begin
                            count_d = from_q;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
`ifdef INTERVAL_TIMER_PAUSE_EN
            S_PAUSED: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            from_q      <= '0;
            to_q        <= '1;
            periodic_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            from_q      <= from_d;
            to_q        <= to_d;
            periodic_q  <= periodic_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed, table-driven bench for interval_timer_ctrl (default build, no pause port).
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfgValid;
    logic       cfgReady;
    logic [7:0] cfgFrom;
    logic [7:0] cfgTo;
    logic       cfgPeriodic;
    logic       start;
    logic       stop;
    logic       tick;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       err;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic       cfgValid;
        logic [7:0] cfgFrom;
        logic [7:0] cfgTo;
        logic       cfgPeriodic;
        logic       start;
        logic       stop;
        logic       tick;
        logic [7:0] expCount;
        logic       expBusy;
        logic       expDone;
        logic       expErr;
        logic       expReady;
    } vec_t;

    vec_t vecs[$];

    interval_timer_ctrl #(.COUNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfgValid),
        .cfg_ready    (cfgReady),
        .cfg_from     (cfgFrom),
        .cfg_to       (cfgTo),
        .cfg_periodic (cfgPeriodic),
        .start        (start),
        .stop         (stop),
        .tick         (tick),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic cv, input logic [7:0] cf, input logic [7:0] ct,
                          input logic cp, input logic st, input logic sp, input logic tk,
                          input logic [7:0] eCount, input logic eBusy, input logic eDone,
                          input logic eErr, input logic eReady);
        vec_t v;
        v.name = name; v.cfgValid = cv; v.cfgFrom = cf; v.cfgTo = ct; v.cfgPeriodic = cp;
        v.start = st; v.stop = sp; v.tick = tk;
        v.expCount = eCount; v.expBusy = eBusy; v.expDone = eDone; v.expErr = eErr; v.expReady = eReady;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic cv, input logic [7:0] cf, input logic [7:0] ct,
                                 input logic cp, input logic st, input logic sp, input logic tk);
        @(negedge clk);
        cfgValid = cv; cfgFrom = cf; cfgTo = ct; cfgPeriodic = cp;
        start = st; stop = sp; tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eCount, input logic eBusy,
                               input logic eDone, input logic eErr, input logic eReady);
        compared++;
        if (count !== eCount || busy !== eBusy || done !== eDone || err !== eErr || cfgReady !== eReady) begin
            mismatched++;
            $display("[TB] FAIL %s: got count=%0d busy=%b done=%b err=%b ready=%b, want count=%0d busy=%b done=%b err=%b ready=%b",
                     name, count, busy, done, err, cfgReady, eCount, eBusy, eDone, eErr, eReady);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfgValid = 0; cfgFrom = 0; cfgTo = 0; cfgPeriodic = 0;
        start = 0; stop = 0; tick = 0;

        //     name            cv  from  to   per st sp tk  count busy done err ready
        addVec("cfg_oneshot",  1,  2,    5,   0,  0, 0, 0,  0,    0,   0,   0,  1);
        addVec("start_os",     0,  0,    0,   0,  1, 0, 0,  2,    1,   0,   0,  0);
        addVec("os_tick3",     0,  0,    0,   0,  0, 0, 1,  3,    1,   0,   0,  0);
        addVec("os_tick4",     0,  0,    0,   0,  0, 0, 1,  4,    1,   0,   0,  0);
        addVec("os_tick5",     0,  0,    0,   0,  0, 0, 1,  5,    1,   0,   0,  0);
        addVec("os_done",      0,  0,    0,   0,  0, 0, 1,  5,    0,   1,   0,  1);
        addVec("os_hold",      0,  0,    0,   0,  0, 0, 1,  5,    0,   0,   0,  1);
        addVec("rej_same_cyc", 1,  6,    2,   0,  1, 0, 0,  5,    0,   0,   1,  1);
        addVec("rej_err_drop", 0,  0,    0,   0,  0, 0, 0,  5,    0,   0,   0,  1);
        addVec("rej_shadow",   0,  0,    0,   0,  1, 0, 0,  5,    0,   0,   1,  1);
        addVec("per_start",    1,  0,    3,   1,  1, 0, 0,  0,    1,   0,   0,  0);
        addVec("per_t1",       0,  0,    0,   0,  0, 0, 1,  1,    1,   0,   0,  0);
        addVec("per_t2",       0,  0,    0,   0,  0, 0, 1,  2,    1,   0,   0,  0);
        addVec("per_t3",       0,  0,    0,   0,  0, 0, 1,  3,    1,   0,   0,  0);
        addVec("per_wrap1",    0,  0,    0,   0,  0, 0, 1,  0,    1,   1,   0,  0);
        addVec("per_t1b",      0,  0,    0,   0,  0, 0, 1,  1,    1,   0,   0,  0);
        addVec("per_t2b",      0,  0,    0,   0,  0, 0, 1,  2,    1,   0,   0,  0);
        addVec("per_t3b",      0,  0,    0,   0,  0, 0, 1,  3,    1,   0,   0,  0);
        addVec("per_wrap2",    0,  0,    0,   0,  0, 0, 1,  0,    1,   1,   0,  0);
        addVec("per_notick",   0,  0,    0,   0,  0, 0, 0,  0,    1,   0,   0,  0);
        addVec("per_t1c",      0,  0,    0,   0,  0, 0, 1,  1,    1,   0,   0,  0);
        addVec("per_t2c",      0,  0,    0,   0,  0, 0, 1,  2,    1,   0,   0,  0);
        addVec("per_t3c",      0,  0,    0,   0,  0, 0, 1,  3,    1,   0,   0,  0);
        addVec("stop_vs_term", 0,  0,    0,   0,  0, 1, 1,  3,    0,   0,   0,  1);
        addVec("start_stop",   0,  0,    0,   0,  1, 1, 0,  3,    0,   0,   0,  1);
        addVec("restart",      0,  0,    0,   0,  1, 0, 0,  0,    1,   0,   0,  0);
        addVec("start_in_run", 0,  0,    0,   0,  1, 0, 1,  1,    1,   0,   0,  0);
        addVec("stop_run",     0,  0,    0,   0,  0, 1, 0,  1,    0,   0,   0,  1);
        addVec("edge_start",   1,  254,  255, 0,  1, 0, 0,  254,  1,   0,   0,  0);
        addVec("edge_t1",      0,  0,    0,   0,  0, 0, 1,  255,  1,   0,   0,  0);
        addVec("edge_done",    0,  0,    0,   0,  0, 0, 1,  255,  0,   1,   0,  1);
        addVec("rearm",        0,  0,    0,   0,  1, 0, 0,  254,  1,   0,   0,  0);
        addVec("rearm_t1",     0,  0,    0,   0,  0, 0, 1,  255,  1,   0,   0,  0);

        // Reset defaults.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cfgValid, vecs[i].cfgFrom, vecs[i].cfgTo, vecs[i].cfgPeriodic,
                          vecs[i].start, vecs[i].stop, vecs[i].tick);
            checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expBusy, vecs[i].expDone,
                        vecs[i].expErr, vecs[i].expReady);
        end

        // Mid-run reset while count sits at the terminal value with tick high.
        @(negedge clk);
        cfgValid = 0; start = 0; stop = 0; tick = 1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        checkOutput("reset_no_done", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        tick = 0;

        // Shadows back at 0 / 255 / one-shot after reset.
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("shadow_reset_start", 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("shadow_reset_tick", 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("final_stop", 1, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval-timer controller that sequences an up-counter between a configured start and end bound. A valid/ready configuration port loads the bounds and mode. Start and stop commands drive the run state machine, and a tick enable advances the count. The block emits a one-cycle `done` pulse at each terminal count and supports one-shot and periodic (auto-reload) operation. It sits between a host/CSR layer and timing-dependent logic.

## Interface
- `COUNT_WIDTH`, 8, width of count and bound fields (≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration can be accepted
- `cfg_from`  in  COUNT_WIDTH  start (reload) value
- `cfg_to`  in  COUNT_WIDTH  terminal value
- `cfg_periodic`  in  1  1 = auto-reload, 0 = one-shot
- `start`  in  1  begin counting (level sampled per cycle)
- `stop`  in  1  abort to IDLE
- `tick`  in  1  count advance enable
- `pause`  in  1  hold count (present only with `INTERVAL_TIMER_PAUSE_EN`)
- `count`  out  COUNT_WIDTH  current count
- `busy`  out  1  state is RUN or PAUSED
- `done`  out  1  one-cycle pulse at terminal count
- `err`  out  1  one-cycle pulse on a rejected start

## Operation
- States:
  - IDLE: after reset or `stop`.
  - RUN: counting.
  - PAUSED: holding; macro only.
  - DONE: one-shot has finished.
- Shadow registers hold `from`, `to` and `periodic`. Reset values are 0, all-ones and 0.
- `cfg_ready` = 1 in IDLE and DONE, 0 otherwise. A transfer occurs when `cfg_valid & cfg_ready` at an edge; the shadow registers update.
- `start` in IDLE or DONE:
  - Effective bounds are the incoming cfg values if a transfer occurs in the same cycle, otherwise the shadow values.
  - If `from > to`: stay put, `err`=1 for one cycle, `count` unchanged.
  - Otherwise: go to RUN with `count <= from`.
- RUN with `tick`=1 and `count != to`: `count <= count + 1`.
- RUN with `tick`=1 and `count == to`:
  - `done`=1.
  - If periodic: `count <= from`, stay in RUN.
  - If one-shot: go to DONE, `count` holds `to`.
- Terminal detection is by compare, never by arithmetic overflow. `to` = 2^W−1 is legal.
- `from == to`: the first tick after start produces `done`.
- `start` while in RUN or PAUSED is ignored; there is no restart.
- `stop` in any state: go to IDLE, `count` holds its value, no `done`.
- Priorities:
  - `stop` beats `start`, `tick` and `pause`.
  - `start` together with `stop` in IDLE leaves the block in IDLE with no `err`.
- DONE → `start` rearms (same rules as IDLE). DONE → `stop` → IDLE.

## Timing
- Reset (asynchronous, immediate) sets:
  - state IDLE, `count`=0
  - `busy`=0, `done`=0, `err`=0, `cfg_ready`=1
  - shadows at their reset values
- `start` sampled at edge N: `busy`=1 and `count`=`from` visible after edge N. The first increment happens at the first edge >N with `tick`=1.
- `done` and `err` are registered. They are high exactly in the cycle after the causing edge and low the following cycle unless re-caused. In periodic mode with continuous `tick`, `done` pulses every (to−from+1) cycles.
- `busy` falls at the edge that enters DONE or IDLE.
- Reset asserted mid-RUN: all outputs return to reset values immediately. No `done` is issued.

## Configuration
- `INTERVAL_TIMER_PAUSE_EN` defined:
  - Adds the `pause` port and the PAUSED state.
  - RUN with `pause`=1 → PAUSED. `tick` is ignored and `count` holds.
  - PAUSED with `pause`=0 → RUN.
  - `pause` and a terminal tick in the same cycle: `pause` wins, no `done`.
  - `busy` stays 1 while PAUSED.
- Not defined: no `pause` port and no PAUSED state. Behaviour is otherwise identical.

## Test plan
- **Reset defaults.** Reset → `count`=0, `busy`=0, `cfg_ready`=1, `done`=0.
- **One-shot.** Config `from`=2, `to`=5, periodic=0, then `start`, continuous `tick` → `count` 2,3,4,5; `done` pulses once; state DONE; `count` holds 5; `cfg_ready`=1.
- **Periodic reload.** Config `from`=0, `to`=3, periodic=1, `tick`=1 → `done` every 4 cycles; `count` returns to 0 after 3; `busy` stays 1.
- **Rejected start.** Config `from`=6, `to`=2, then `start` → `err` one cycle, state IDLE, `busy`=0, `count` unchanged.
- **Stop versus terminal tick.** `stop` asserted in the same cycle as the terminal tick (`count`=`to`) → IDLE, no `done`, `busy`=0.
- **Width edge and mid-run reset.** W=8, `from`=254, `to`=255: `done` on the second tick. Assert `rst` mid-RUN → immediate reset values, no `done`.
